// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU memory bus: arbiter state encoding and the
// default address/data widths used by the CPU core, the arbiter and the memory
// model.
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  // Arbiter transaction phases: pick a requester, strobe memory, wait out the
  // fixed read latency, then pulse completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage : cpu_bus_pkg

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the requester-side handshake and the memory-side strobe/data signals
// of the shared memory bus.
//
// Signals:
//   req_valid/req_we   [N_REQ]         per-requester request and write enable
//   req_addr           [N_REQ*ADDR_W]  packed addresses, slice k = requester k
//   req_wdata          [N_REQ*DATA_W]  packed write data, same slicing
//   req_done           [N_REQ]         one-hot completion pulse
//   req_rdata          [DATA_W]        shared read data, valid with req_done
//   grant              [N_REQ]         one-hot owner of current transaction
//   busy                               transaction in progress
//   mem_en/mem_we                      memory strobe and write qualifier
//   mem_addr/mem_wdata                 memory address and write data
//   mem_rdata          [DATA_W]        memory read data
//
// Modports:
//   slave  - the arbiter: serves requests, drives the memory strobe
//   master - the environment: requesters plus the memory model
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_done;
  logic [DATA_W-1:0]       req_rdata;
  logic [N_REQ-1:0]        grant;
  logic                    busy;

  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_done, req_rdata, grant, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_done, req_rdata, grant, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface : mem_bus_arbiter_if

// File: rtl/mem_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans requesters starting just after
// the previous winner, wrapping modulo N_REQ, and returns the first one found.
//
// Ports:
//   req        in  [N_REQ]  pending requests
//   last       in  [IDX_W]  index of the previous winner
//   gnt        out [N_REQ]  one-hot selected requester (0 if none)
//   idx        out [IDX_W]  index of the selected requester
//   any_valid  out          at least one request pending
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  always_comb begin
    int   k;
    logic found;
    // NOTE: every output and temporary gets a default before the scan so no
    // path through the loop can leave a value unassigned and infer a latch.
    gnt       = '0;
    idx       = '0;
    k         = 0;
    found     = 1'b0;
    any_valid = |req;
    // Offsets 1..N_REQ visit every requester once, the previous winner last.
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(last) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      if (!found && req[IDX_W'(k)]) begin
        found            = 1'b1;
        gnt[IDX_W'(k)]   = 1'b1;
        idx              = IDX_W'(k);
      end
    end
  end

endmodule : rr_pick

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-port, fixed-latency memory between N_REQ requesters
// (instruction fetch, data load/store, program loader). One access at a time,
// round-robin priority, uniform timing for reads and writes:
//   IDLE (pick) -> ISSUE (mem_en) -> WAIT (MEM_LAT cycles) -> DONE (req_done)
//
// Ports:
//   clk  in   system clock, rising edge
//   r    in   synchronous active-low reset
//   bus  slave modport of mem_bus_arbiter_if (requester and memory signals)
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   ADDR_W   memory address width
//   DATA_W   memory data width
//   MEM_LAT  cycles from mem_en to valid mem_rdata (1..15)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            r,
  mem_bus_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  // Priority restarts at requester 0 after reset.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  last;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  win_oh;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req       (bus.req_valid),
    .last      (last),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: r is only looked at on the clock edge, so it
    // appears inside the clocked branch rather than in the sensitivity list.
    if (!r) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // in the design samples pre-edge values regardless of block ordering.
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    win_oh    = '0;
    win_oh[winner] = 1'b1;

    unique case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant is derived from the registered winner, so it is zero in IDLE and
  // clears on the same edge that returns the FSM to IDLE.
  assign bus.busy      = (state != IDLE);
  assign bus.grant     = bus.busy ? win_oh : '0;
  assign bus.req_done  = (state == DONE) ? win_oh : '0;
  assign bus.req_rdata = rdata_q;

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = bus.mem_en & cap_we;
  assign bus.mem_addr  = cap_addr;
  assign bus.mem_wdata = cap_wdata;

  // ---------------------------------------------------------------------------
  // Datapath: capture of the winning request, latency counter, read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!r) begin
      winner    <= '0;
      last      <= LAST_RST;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Requester inputs are only sampled here; later changes are ignored.
          if (pick_any) begin
            winner    <= pick_idx;
            last      <= pick_idx;
            cap_addr  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            cap_we    <= bus.req_we[pick_idx];
            cap_wdata <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          cnt <= CNT_LOAD;
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          // Count value 1 marks the cycle in which mem_rdata is valid; writes
          // run the same path but return zero.
          if (cnt == CNT_ONE) begin
            rdata_q <= cap_we ? '0 : bus.mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiter instances share clock, reset and requester stimulus: lane 0 with
// MEM_LAT=1 and lane 1 with MEM_LAT=4. Each lane has a memory model that only
// presents read data in the exact latency cycle, and a transaction-level
// reference model that derives every output from the transaction start cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clk;
  logic r;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [N-1:0]    rv;
  logic [N-1:0]    rwe;
  logic [N*AW-1:0] raddr;
  logic [N*DW-1:0] rwd;

  logic [N-1:0]  done_v  [2];
  logic [N-1:0]  grant_v [2];
  logic          busy_v  [2];
  logic          en_v    [2];
  logic          we_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wd_v    [2];
  logic [DW-1:0] rdata_v [2];
  int            en_cnt_v   [2];
  int            done_cnt_v [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [7:0] i);
    return (i == 8'h40) ? 8'hA5 : (i ^ 8'h3C);
  endfunction

  // ---------------------------------------------------------------------------
  // Lanes: DUT, memory model, reference model
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : gen_lane
    localparam int L = (g == 0) ? 1 : 4;

    mem_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)
    ) dut (
      .clk (clk),
      .r   (r),
      .bus (bus)
    );

    assign bus.req_valid = rv;
    assign bus.req_we    = rwe;
    assign bus.req_addr  = raddr;
    assign bus.req_wdata = rwd;

    assign done_v[g]  = bus.req_done;
    assign grant_v[g] = bus.grant;
    assign busy_v[g]  = bus.busy;
    assign en_v[g]    = bus.mem_en;
    assign we_v[g]    = bus.mem_we;
    assign addr_v[g]  = bus.mem_addr;
    assign wd_v[g]    = bus.mem_wdata;
    assign rdata_v[g] = bus.req_rdata;

    // Memory: byte array indexed by the low address byte; read data travels a
    // delay line and is driven only in the cycle MEM_LAT after mem_en.
    logic [7:0]  mem [256];
    logic [15:0] pv;
    logic [7:0]  pd  [16];
    int          en_cnt;
    int          done_cnt;

    initial begin
      pv       = '0;
      en_cnt   = 0;
      done_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = init_byte(8'(i));
      for (int i = 0; i < 16; i++) pd[i] = '0;
    end

    always @(posedge clk) begin
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1)
        mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      pv    <= {pv[14:0], (bus.mem_en === 1'b1) && (bus.mem_we !== 1'b1)};
      pd[0] <= mem[bus.mem_addr[7:0]];
      for (int s = 1; s < 16; s++) pd[s] <= pd[s-1];
      if (bus.mem_en === 1'b1) en_cnt <= en_cnt + 1;
      if (bus.req_done !== '0) done_cnt <= done_cnt + 1;
    end

    assign bus.mem_rdata  = pv[L-1] ? pd[L-1] : 8'hEE;
    assign en_cnt_v[g]    = en_cnt;
    assign done_cnt_v[g]  = done_cnt;

    // Reference model: a transaction picked in cycle t0 owns the bus for
    // cycles t0+1 .. t0+L+2; strobe at offset 1, completion at offset L+2.
    bit         armed = 1'b0;
    bit         rst_seen = 1'b0;
    bit         active = 1'b0;
    int         t0 = 0;
    int         win = 0;
    int         last = N - 1;
    bit         wr = 1'b0;
    logic [15:0] ma = '0;
    logic [7:0]  mwd = '0;
    logic [7:0]  erd = '0;

    always @(negedge clk) begin
      int          p;
      bit          in_txn;
      bit          found;
      logic [N-1:0] oh;
      string       pfx;
      pfx    = $sformatf("lane%0d", g);
      p      = cyc - t0;
      in_txn = active && (p >= 1) && (p <= L + 2);
      oh     = N'(1) << win;
      found  = 1'b0;

      if (armed) begin
        if (rst_seen) begin
          check({pfx, " rst grant"},     32'(grant_v[g]), 0);
          check({pfx, " rst busy"},      32'(busy_v[g]),  0);
          check({pfx, " rst done"},      32'(done_v[g]),  0);
          check({pfx, " rst rdata"},     32'(rdata_v[g]), 0);
          check({pfx, " rst mem_en"},    32'(en_v[g]),    0);
          check({pfx, " rst mem_we"},    32'(we_v[g]),    0);
          check({pfx, " rst mem_addr"},  32'(addr_v[g]),  0);
          check({pfx, " rst mem_wdata"}, 32'(wd_v[g]),    0);
        end else begin
          check({pfx, " grant"},  32'(grant_v[g]), in_txn ? 32'(oh) : 0);
          check({pfx, " busy"},   32'(busy_v[g]),  32'(in_txn));
          check({pfx, " mem_en"}, 32'(en_v[g]),    32'(in_txn && p == 1));
          check({pfx, " done"},   32'(done_v[g]),  (in_txn && p == L + 2) ? 32'(oh) : 0);
          if (in_txn && p == 1) begin
            check({pfx, " mem_we"},    32'(we_v[g]), 32'(wr));
            check({pfx, " mem_wdata"}, 32'(wd_v[g]), 32'(mwd));
          end
          if (in_txn && p <= L + 1)
            check({pfx, " mem_addr"}, 32'(addr_v[g]), 32'(ma));
          if (in_txn && p == L + 2)
            check({pfx, " rdata"}, 32'(rdata_v[g]), 32'(erd));
        end
      end

      if (!r) begin
        armed    = 1'b1;
        rst_seen = 1'b1;
        active   = 1'b0;
        last     = N - 1;
      end else begin
        rst_seen = 1'b0;
        if (!in_txn && rv != '0) begin
          for (int i = 1; i <= N; i++) begin
            if (!found && rv[(last + i) % N]) begin
              found = 1'b1;
              win   = (last + i) % N;
            end
          end
          last   = win;
          t0     = cyc;
          active = 1'b1;
          wr     = rwe[win];
          ma     = raddr[win*AW +: AW];
          mwd    = rwd[win*DW +: DW];
          erd    = wr ? 8'h00 : mem[ma[7:0]];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input bit we,
                         input logic [15:0] a, input logic [7:0] d);
    rv[k]            = v;
    rwe[k]           = we;
    raddr[k*AW +: AW] = a;
    rwd[k*DW +: DW]   = d;
  endtask

  task automatic wait_done(input int lane, input logic [N-1:0] mask,
                           input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_v[lane] === mask) begin
        at = cyc;
        break;
      end
      tick(1);
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done lane%0d: no done=%b within %0d cycles", lane, mask, budget);
    end
  endtask

  task automatic wait_mem_en(input int lane, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (en_v[lane] === 1'b1) begin
        at = cyc;
        break;
      end
      tick(1);
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_mem_en lane%0d: no strobe within %0d cycles", lane, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with hand-computed expectations
  // ---------------------------------------------------------------------------
  logic [N-1:0] grant_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    int t;
    int at;
    int prev;
    int e0;
    int d0;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    r        = 1'b0;
    rv       = '0;
    rwe      = '0;
    raddr    = '0;
    rwd      = '0;

    // Reset, then a single read of 0x0040 (memory holds 0xA5).
    tick(3);
    check("reset busy",     32'(busy_v[0]),  0);
    check("reset grant",    32'(grant_v[0]), 0);
    check("reset done",     32'(done_v[0]),  0);
    check("reset mem_en",   32'(en_v[0]),    0);
    check("reset rdata",    32'(rdata_v[0]), 0);
    check("reset mem_addr", 32'(addr_v[0]),  0);
    r = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0040, 8'h00);
    t = cyc;
    tick(1);
    check("read mem_en",   32'(en_v[0]),   1);
    check("read mem_addr", 32'(addr_v[0]), 32'h0040);
    wait_done(0, 3'b001, 10, at);
    check("read latency", 32'(at - t), 3);
    check("read rdata",   32'(rdata_v[0]), 32'hA5);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick(6);

    // Write from requester 1.
    set_req(1, 1'b1, 1'b1, 16'h1234, 8'h5A);
    t  = cyc;
    e0 = en_cnt_v[0];
    tick(1);
    check("write mem_en",    32'(en_v[0]), 1);
    check("write mem_we",    32'(we_v[0]), 1);
    check("write mem_addr",  32'(addr_v[0]), 32'h1234);
    check("write mem_wdata", 32'(wd_v[0]), 32'h5A);
    wait_done(0, 3'b010, 10, at);
    check("write latency", 32'(at - t), 3);
    check("write rdata",   32'(rdata_v[0]), 0);
    set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick(6);
    check("write single strobe", 32'(en_cnt_v[0] - e0), 1);

    // Contention: all three valid from a fresh reset.
    r = 1'b0;
    tick(2);
    r = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    set_req(1, 1'b1, 1'b1, 16'h0155, 8'h77);
    set_req(2, 1'b1, 1'b0, 16'h0102, 8'h00);
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      wait_mem_en(0, 8, at);
      check($sformatf("rr grant %0d", i), 32'(grant_v[0]), 32'(grant_seq[i]));
      if (i > 0) check($sformatf("rr spacing %0d", i), 32'(at - prev), 4);
      prev = at;
      tick(1);
    end
    rv = '0;
    tick(10);

    // Latency parameter: lane 1 (MEM_LAT=4), read of 0x0003 -> 0x3F.
    r = 1'b0;
    tick(2);
    r = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0003, 8'h00);
    t = cyc;
    wait_done(1, 3'b001, 12, at);
    check("lat4 latency", 32'(at - t), 6);
    check("lat4 rdata",   32'(rdata_v[1]), 32'h3F);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick(10);

    // Withdrawal: requester 2 drops valid during WAIT.
    set_req(2, 1'b1, 1'b0, 16'h0200, 8'h00);
    t  = cyc;
    d0 = done_cnt_v[0];
    tick(2);
    check("withdraw busy", 32'(busy_v[0]), 1);
    set_req(2, 1'b0, 1'b0, 16'h0200, 8'h00);
    wait_done(0, 3'b100, 10, at);
    check("withdraw latency", 32'(at - t), 3);
    tick(5);
    check("withdraw one pulse", 32'(done_cnt_v[0] - d0), 1);

    // Back-to-back: requester 0 holds valid through done.
    set_req(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    t = cyc;
    wait_done(0, 3'b001, 10, at);
    check("b2b first latency", 32'(at - t), 3);
    tick(2);
    check("b2b second mem_en", 32'(en_v[0]), 1);
    check("b2b second grant",  32'(grant_v[0]), 32'b001);
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick(10);

    // Reset during WAIT, then only requester 1 valid.
    set_req(0, 1'b1, 1'b0, 16'h0020, 8'h00);
    tick(2);
    check("abort busy before", 32'(busy_v[0]), 1);
    d0 = done_cnt_v[0];
    r  = 1'b0;
    set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h0021, 8'h00);
    tick(1);
    check("abort busy",  32'(busy_v[0]),  0);
    check("abort grant", 32'(grant_v[0]), 0);
    check("abort done",  32'(done_v[0]),  0);
    r = 1'b1;
    tick(1);
    check("post-reset grant", 32'(grant_v[0]), 32'b010);
    wait_done(0, 3'b010, 10, at);
    tick(1);
    check("abort no extra done", 32'(done_cnt_v[0] - d0), 1);
    set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
